// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line idle level and the
// transmit scheduler state encoding.
package uart_pkg;

    localparam int   UART_FRAME_BITS = 10;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } tx_sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter with a sticky lock override.
// The search starts one past last_grant and wraps modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          lock_valid,
    input  logic [IW-1:0] lock_id,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] cand;

    // A valid lock wins outright; otherwise the first requester after
    // last_grant wins, so the previous winner is considered last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        if (lock_valid && req[lock_id]) begin
            grant[lock_id] = 1'b1;
            grant_idx      = lock_id;
            found          = 1'b1;
        end
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_grant) + k) % N);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte producers: accepts a
// byte, pulses tx_enable, follows tx_busy to frame end, then idles gap_cycles.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 16,
    localparam int IDW       = $clog2(NUM_REQ),
    localparam int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [15:0]          gap_cycles,
    input  logic                 tx_busy,
    output logic                 tx_enable,
    output logic [7:0]           tx_data,
    output logic [IDW-1:0]       grant_id,
    output logic                 sched_busy,
    output logic [15:0]          frame_count
);

    tx_sched_state_t    state, state_next;
    logic [15:0]        gap_cnt;
    logic [BCW-1:0]     burst_cnt;
    logic               lock_pending;
    logic               lock_valid;
    logic               accept;
    logic               frame_done;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDW-1:0]     arb_idx;

    // The lock only holds while the burst budget is not yet exhausted.
    assign lock_valid = lock_pending && (burst_cnt < BCW'(MAX_BURST));
    assign accept     = (state == ST_IDLE) && !tx_busy && (|req_valid);
    assign frame_done = (state == ST_WAIT_DONE) && !tx_busy;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (grant_id),
        .lock_valid (lock_valid),
        .lock_id    (grant_id),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (accept) state_next = ST_LAUNCH;
            ST_LAUNCH:    state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) state_next = (gap_cycles != 16'd0) ? ST_GAP : ST_IDLE;
            ST_GAP:       if (gap_cnt <= 16'd1) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = accept ? arb_grant : '0;
        sched_busy = (state != ST_IDLE);
    end

    // Everything captured at accept time; tx_data then holds until the
    // next accept, so the transmitter may sample it at any point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_enable    <= 1'b0;
            tx_data      <= {8{UART_IDLE_LEVEL}};
            grant_id     <= '0;
            lock_pending <= 1'b0;
            burst_cnt    <= '0;
        end else begin
            tx_enable <= accept;
            if (accept) begin
                tx_data      <= req_data[8*arb_idx +: 8];
                grant_id     <= arb_idx;
                lock_pending <= req_lock[arb_idx];
                burst_cnt    <= (lock_valid && arb_idx == grant_id) ? burst_cnt + BCW'(1) : BCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= 16'd0;
            gap_cnt     <= 16'd0;
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
                gap_cnt     <= gap_cycles;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queued producers, a behavioural UART
// transmitter and a queue-based arbitration model.
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int MB = 16;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_lock, req_ready;
    logic [8*N-1:0] req_data;
    logic [15:0]    gap_cycles;
    logic           tx_busy, tx_enable, sched_busy;
    logic [7:0]     tx_data;
    logic [IW-1:0]  grant_id;
    logic [15:0]    frame_count;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_ready(req_ready), .gap_cycles(gap_cycles),
        .tx_busy(tx_busy), .tx_enable(tx_enable), .tx_data(tx_data),
        .grant_id(grant_id), .sched_busy(sched_busy), .frame_count(frame_count)
    );

    // Transmitter model: start bit, 8 data bits LSB first, stop bit
    logic                       model_busy, data_out, force_busy;
    int                         baud, bit_idx, tick;
    logic [UART_FRAME_BITS-1:0] frame_bits;
    assign frame_bits = {1'b1, tx_data, 1'b0};
    assign tx_busy    = model_busy | force_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_busy <= 1'b0; data_out <= UART_IDLE_LEVEL; bit_idx <= 0; tick <= 0;
        end else if (!model_busy) begin
            if (tx_enable) begin
                model_busy <= 1'b1; data_out <= frame_bits[0]; bit_idx <= 0; tick <= 0;
            end
        end else if (tick == baud - 1) begin
            tick <= 0;
            if (bit_idx == UART_FRAME_BITS - 1) begin
                model_busy <= 1'b0; data_out <= UART_IDLE_LEVEL;
            end else begin
                bit_idx  <= bit_idx + 1;
                data_out <= frame_bits[bit_idx + 1];
            end
        end else begin
            tick <= tick + 1;
        end
    end

    logic [7:0]   q_data [N][32];
    logic         q_lock [N][32];
    int           q_cnt [N], q_ptr [N], q_start [N];
    int           total = 0, bad = 0, cyc = 0;
    int           m_last = 0, m_burst = 0, gap_now = 0;
    bit           m_lock = 0;
    logic [15:0]  m_frames = 16'd0;
    bit           prev_en = 0, prev_mbusy = 0, acc_pending = 0, fall_valid = 0, busy_req = 0, rec_on = 0;
    int           acc_cyc = 0, fall_cyc = 0;
    logic [7:0]   exp_byte = 8'h00;
    logic [N-1:0] last_ready;
    int           order_q[$], acc_q[$], fall_q[$];
    logic [7:0]   data_q[$];
    logic         rec_bits[$];

    task automatic clear_queues();
        for (int r = 0; r < N; r++) begin q_cnt[r] = 0; q_ptr[r] = 0; q_start[r] = 0; end
        order_q.delete(); data_q.delete(); acc_q.delete(); fall_q.delete();
        fall_valid = 0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input bit lk);
        q_data[r][q_cnt[r]] = d;
        q_lock[r][q_cnt[r]] = lk;
        q_cnt[r]++;
    endtask

    function automatic bit drained();
        for (int r = 0; r < N; r++) if (q_ptr[r] < q_cnt[r]) return 0;
        return 1;
    endfunction

    function automatic int model_pick(input logic [N-1:0] v);
        logic [IW-1:0] ix;
        if (m_lock && m_burst < MB && v[IW'(m_last)]) return m_last;
        for (int k = 1; k <= N; k++) begin
            ix = IW'((m_last + k) % N);
            if (v[ix]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive producers, then scoreboard launch, frame end and grants
    task automatic step();
        logic [N-1:0] v;
        int w, e;
        bit lock_applied;
        @(negedge clk);
        cyc++;
        force_busy = busy_req;
        for (int r = 0; r < N; r++) begin
            v[r]              = (q_ptr[r] < q_cnt[r]) && (cyc >= q_start[r]);
            req_valid[r]      = v[r];
            req_data[8*r +: 8] = v[r] ? q_data[r][q_ptr[r]] : 8'($urandom);
            req_lock[r]       = v[r] ? q_lock[r][q_ptr[r]] : 1'($urandom);
        end
        #1;
        last_ready = req_ready;
        if (tx_enable) begin
            total++;
            if (prev_en !== 1'b0) begin bad++; $display("[TB] FAIL enable_width: tx_enable high two cycles at cyc %0d", cyc); end
            total++;
            if (!acc_pending || cyc != acc_cyc + 1) begin bad++; $display("[TB] FAIL launch_time: launch cyc %0d accept cyc %0d pending %0d", cyc, acc_cyc, acc_pending); end
            total++;
            if (tx_data !== exp_byte) begin bad++; $display("[TB] FAIL launch_data: got %h want %h", tx_data, exp_byte); end
            acc_pending = 0;
        end
        prev_en = tx_enable;
        if (prev_mbusy && !model_busy) begin
            m_frames++; fall_cyc = cyc; fall_valid = 1; fall_q.push_back(cyc);
            total++;
            if (sched_busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_at_fall: sched_busy %b want 1", sched_busy); end
        end
        prev_mbusy = model_busy;
        if (fall_valid && cyc == fall_cyc + 1) begin
            total++;
            if (frame_count !== m_frames) begin bad++; $display("[TB] FAIL frame_count: got %0d want %0d", frame_count, m_frames); end
            total++;
            if (sched_busy !== (gap_now != 0)) begin bad++; $display("[TB] FAIL busy_after_fall: sched_busy %b want %b", sched_busy, gap_now != 0); end
        end
        if (fall_valid && cyc > fall_cyc && cyc < fall_cyc + gap_now + 1) begin
            total++;
            if (req_ready !== '0) begin bad++; $display("[TB] FAIL early_grant: ready %b during gap at cyc %0d", req_ready, cyc); end
        end
        if (fall_valid && cyc == fall_cyc + gap_now + 1 && |v && !force_busy) begin
            total++;
            if (req_ready == '0) begin bad++; $display("[TB] FAIL late_grant: ready %b want a grant at cyc %0d", req_ready, cyc); end
        end
        if (req_ready != '0) begin
            total++;
            if (!$onehot(req_ready) || (req_ready & ~v) != '0) begin
                bad++; $display("[TB] FAIL ready_shape: ready %b valid %b", req_ready, v);
            end
            w = 0;
            for (int r = N - 1; r >= 0; r--) if (req_ready[r]) w = r;
            e = model_pick(v);
            total++;
            if (w != e) begin bad++; $display("[TB] FAIL grant_order: got %0d want %0d", w, e); end
            lock_applied = m_lock && (m_burst < MB) && v[IW'(m_last)];
            if (lock_applied && w == m_last) m_burst++;
            else m_burst = 1;
            m_lock   = q_lock[w][q_ptr[w]];
            m_last   = w;
            exp_byte = q_data[w][q_ptr[w]];
            order_q.push_back(w); data_q.push_back(exp_byte); acc_q.push_back(cyc);
            acc_cyc = cyc; acc_pending = 1;
            q_ptr[w]++;
        end
        if (rec_on && model_busy) rec_bits.push_back(data_out);
    endtask

    task automatic run_traffic(input int budget);
        int n = 0;
        while (!(drained() && !model_busy && !sched_busy && !acc_pending) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (n >= budget) begin bad++; $display("[TB] FAIL traffic_timeout: %0d cycles used, budget %0d", n, budget); end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++; if (tx_enable !== 1'b0) begin bad++; $display("[TB] FAIL %s_tx_enable: got %b want 0", tag, tx_enable); end
        total++; if (tx_data !== 8'hFF) begin bad++; $display("[TB] FAIL %s_tx_data: got %h want ff", tag, tx_data); end
        total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL %s_req_ready: got %b want 0", tag, req_ready); end
        total++; if (grant_id !== '0) begin bad++; $display("[TB] FAIL %s_grant_id: got %0d want 0", tag, grant_id); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("[TB] FAIL %s_sched_busy: got %b want 0", tag, sched_busy); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL %s_frame_count: got %0d want 0", tag, frame_count); end
    endtask

    task automatic test_reset();
        rst = 1'b1; force_busy = 1'b0; baud = 1; gap_cycles = 16'd0; gap_now = 0;
        req_valid = '0; req_lock = '0; req_data = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4] = '{8'h22, 8'h33, 8'h44, 8'h11};
        int         exp_o [4] = '{1, 2, 3, 0};
        clear_queues();
        push(0, 8'h11, 0); push(1, 8'h22, 0); push(2, 8'h33, 0); push(3, 8'h44, 0);
        run_traffic(300);
        total++;
        if (order_q.size() != 4) begin bad++; $display("[TB] FAIL rr_count: got %0d grants want 4", order_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (order_q[i] != exp_o[i] || data_q[i] !== exp_d[i]) begin
                    bad++; $display("[TB] FAIL rr_seq%0d: got id %0d byte %h want id %0d byte %h", i, order_q[i], data_q[i], exp_o[i], exp_d[i]);
                end
            end
        end
        total++;
        if (frame_count !== 16'd4) begin bad++; $display("[TB] FAIL rr_frames: got %0d want 4", frame_count); end
    endtask

    task automatic test_single_frame();
        logic [9:0] exp_bits = 10'b1101001010;
        clear_queues();
        baud = 4;
        rec_bits.delete(); rec_on = 1;
        push(2, 8'hA5, 0);
        run_traffic(200);
        rec_on = 0;
        total++;
        if (rec_bits.size() != 40) begin bad++; $display("[TB] FAIL frame_len: got %0d busy cycles want 40", rec_bits.size()); end
        else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (rec_bits[i*4 + 2] !== exp_bits[i]) begin
                    bad++; $display("[TB] FAIL serial_bit%0d: got %b want %b", i, rec_bits[i*4 + 2], exp_bits[i]);
                end
            end
        end
        baud = 1;
    endtask

    task automatic test_gap();
        clear_queues();
        gap_cycles = 16'd5; gap_now = 5;
        push(1, 8'h3C, 0); push(1, 8'hC3, 0);
        run_traffic(300);
        total++;
        if (acc_q.size() != 2 || fall_q.size() < 1) begin bad++; $display("[TB] FAIL gap_events: accepts %0d falls %0d", acc_q.size(), fall_q.size()); end
        else begin
            total++;
            if (acc_q[1] - fall_q[0] != 6) begin bad++; $display("[TB] FAIL gap_len: got %0d want 6", acc_q[1] - fall_q[0]); end
        end
        gap_cycles = 16'd0; gap_now = 0;
    endtask

    task automatic test_busy_hold();
        clear_queues();
        busy_req = 1;
        push(3, 8'h77, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (last_ready !== '0) begin bad++; $display("[TB] FAIL busy_hold%0d: ready %b want 0", i, last_ready); end
        end
        busy_req = 0;
        step();
        total++;
        if (last_ready !== 4'b1000) begin bad++; $display("[TB] FAIL busy_release: ready %b want 1000", last_ready); end
        run_traffic(100);
    endtask

    task automatic test_lock_burst();
        int run = 0;
        clear_queues();
        for (int i = 0; i < 20; i++) push(0, 8'($urandom), 1);
        push(1, 8'hB1, 0); push(1, 8'hB2, 0);
        q_start[1] = cyc + 3;
        run_traffic(2000);
        while (run < order_q.size() && order_q[run] == 0) run++;
        total++;
        if (run != 16) begin bad++; $display("[TB] FAIL burst_len: got %0d want 16", run); end
        total++;
        if (order_q.size() <= 16 || order_q[16] != 1) begin bad++; $display("[TB] FAIL burst_rotate: requester 1 not granted after burst"); end
    endtask

    task automatic test_random();
        for (int round = 0; round < 4; round++) begin
            clear_queues();
            gap_now = int'($urandom_range(0, 3));
            gap_cycles = 16'(gap_now);
            baud = int'($urandom_range(1, 2));
            for (int r = 0; r < N; r++) begin
                int cnt = int'($urandom_range(0, 6));
                for (int k = 0; k < cnt; k++) push(r, 8'($urandom), 1'($urandom));
                q_start[r] = cyc + int'($urandom_range(0, 8));
            end
            run_traffic(3000);
        end
        gap_cycles = 16'd0; gap_now = 0; baud = 1;
    endtask

    task automatic test_wrap();
        clear_queues();
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frame_count;
        m_frames = 16'hFFFF;
        push(2, 8'h5E, 0);
        run_traffic(200);
        total++;
        if (frame_count !== 16'h0000) begin bad++; $display("[TB] FAIL frame_wrap: got %h want 0000", frame_count); end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        clear_queues();
        baud = 4;
        push(3, 8'h5A, 0);
        while (!model_busy && n < 20) begin step(); n++; end
        repeat (3) step();
        total++;
        if (!model_busy) begin bad++; $display("[TB] FAIL midframe_start: transmitter busy %b want 1", model_busy); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 0; m_lock = 0; m_burst = 0; m_frames = 16'd0;
        prev_mbusy = 0; prev_en = 0; acc_pending = 0; fall_valid = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (last_ready !== '0) begin bad++; $display("[TB] FAIL reserve%0d: ready %b want 0", i, last_ready); end
        end
        baud = 1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_frame();
        test_gap();
        test_busy_hold();
        test_lock_burst();
        test_random();
        test_wrap();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART `transmitter` between `NUM_REQ` byte producers (e.g., CPU APB write path, debug monitor, DMA). It accepts bytes over per-requester valid/ready handshakes, launches each frame with a one-cycle `tx_enable` pulse, and tracks the transmitter's `busy` to completion. It also inserts a programmable inter-frame gap and supports bounded multi-byte bursts by one requester. It sits between the APB serial register block and the `transmitter` instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `MAX_BURST`, 16, max consecutive frames granted to a locking requester before forced rotation
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  requester i has a byte pending
- `req_data`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- `req_lock`  in  NUM_REQ  requester i requests to keep the grant for its next byte
- `req_ready`  out  NUM_REQ  one-hot accept pulse; byte taken when valid&ready
- `gap_cycles`  in  16  idle clk cycles inserted after each frame (0 = none)
- `tx_busy`  in  1  `busy` from transmitter
- `tx_enable`  out  1  one-cycle launch pulse to transmitter
- `tx_data`  out  8  byte to transmitter, stable from launch until frame end
- `grant_id`  out  $clog2(NUM_REQ)  index of last accepted requester
- `sched_busy`  out  1  high in any state except IDLE
- `frame_count`  out  16  frames completed, wraps 0xFFFF->0

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: when `tx_busy`=0 and any `req_valid`, select the winner and assert `req_ready[winner]` combinationally in the same cycle. Register `req_data[winner]` into `tx_data` and set `grant_id`. Go to LAUNCH. If `tx_busy`=1, grant nothing and stay.
- LAUNCH: `tx_enable`=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until `tx_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: stay until `tx_busy`=0. Then increment `frame_count` and go to GAP if `gap_cycles`≠0, else to IDLE.
- GAP: down-counter loaded with `gap_cycles` on entry. Exit to IDLE when it reaches 1. Total idle is exactly `gap_cycles` cycles; `gap_cycles` is sampled on entry only.
- Arbitration: priority starts at `grant_id`+1 modulo NUM_REQ, searching upward.
- Lock: if `req_lock[g]` was 1 at accept and `burst_cnt` < MAX_BURST, requester g has top priority at the next IDLE if `req_valid[g]`=1. `burst_cnt` resets to 1 on a grant to a different requester or a non-locked grant, and increments on locked re-grant. When `burst_cnt`=MAX_BURST, normal rotation applies.
- Valid data may change freely while ready=0; the scheduler never samples `req_data` outside the accept cycle.

## Timing
- Reset values: `tx_enable`=0, `tx_data`=8'hFF, `req_ready`=0, `grant_id`=0, `sched_busy`=0, `frame_count`=0, state IDLE, `burst_cnt`=0.
- Accept (cycle n) -> `tx_enable`=1 at cycle n+1 -> transmitter `busy` rises at n+2.
- Back-to-back with `gap_cycles`=0: the next accept occurs in the first cycle after `tx_busy` is seen low in WAIT_DONE (`tx_busy` fall + 1).
- `tx_enable` is registered and never high for two consecutive cycles.
- `tx_data` holds its value from LAUNCH until the next accept.
- Reset asserted mid-frame: all state returns to reset values immediately. A requester whose byte was already accepted is not re-served.
- `req_valid` dropping while in a non-IDLE state has no effect; there is no abort.

## Structure
- Shared package `uart_pkg`: `tx_sched_state_t` enum, `UART_FRAME_BITS`=10, `UART_IDLE_LEVEL`=1'b1.
- Sub-module `rr_arbiter`: parameter N; inputs `req`, `last_grant`, `lock_valid`, `lock_id`; outputs one-hot `grant` and `grant_idx`; purely combinational.
- Top contains the FSM, gap counter, burst counter, and frame counter.

## Test plan
- Reset, then all valid with bytes 0x11/0x22/0x33/0x44 and `gap_cycles`=0 -> accept order 1,2,3,0 (grant_id starts 0). `tx_data` sequence is 0x22,0x33,0x44,0x11, and `frame_count`=4.
- Single requester 2, byte 0xA5, with a real transmitter at baud 4 -> `tx_enable` is one cycle, `data_out` shows 0,1,0,1,0,0,1,0,1,1, and `sched_busy` falls at the `busy` fall + 1.
- `gap_cycles`=5, two queued bytes -> exactly 5 idle cycles between `busy` fall+1 and the next `req_ready`.
- Requester 0 holding lock with 20 bytes, requester 1 valid, MAX_BURST=16 -> requester 0 is granted 16 consecutive times, then requester 1 is granted.
- `tx_busy` forced high at accept time -> no `req_ready` until `tx_busy` drops. Separately, assert `rst` in WAIT_DONE -> next cycle all outputs hold reset values.
- `frame_count` preset via 65536 frames (or a force to 0xFFFF) -> wraps to 0.
